fir_coeff_sched_ctrl: RTL and testbench
=======================================

// Module: fir_coeff_sched_ctrl
// PURPOSE
//  Controller for the transposed FIR multiply/add/shift datapath. Generates the 300 kHz sample strobe from
//  the 12 MHz clock, holds a double-buffered coefficient bank (shadow written by host, active feeding the
//  multipliers), and swaps banks only on a sample boundary so one sample never sees mixed coefficient sets.
// PARAMETERS
//  DIV      40  clock cycles per sample strobe (12 MHz / 300 kHz); legal range 4..255
//  NUM_TAP  12  coefficients in the bank (three per datapath section x 4 sections)
//  COEFF_W  16  signed coefficient width
// PORTS
//  iClk_12M      in   1                  system clock, 12 MHz
//  iRsn          in   1                  reset, asynchronous, active-low
//  iEnFilter     in   1                  level: 1 = run filter, 0 = stop
//  iCoeffWr      in   1                  one-cycle write strobe into shadow bank
//  iCoeffAddr    in   4                  shadow tap index 0..NUM_TAP-1
//  iCoeffData    in   COEFF_W            signed coefficient value
//  iCommit       in   1                  one-cycle request: copy shadow -> active
//  iClrErr       in   1                  clears oWrErr
//  oEnSample_300k out 1                  one-cycle sample enable to datapath
//  oEnMul        out  4                  per-section multiplier enable
//  oEnAdd        out  1                  adder enable
//  oEnAcc        out  1                  accumulator/shift enable
//  oCoeff        out  NUM_TAP*COEFF_W    active bank, tap k at [k*COEFF_W +: COEFF_W]
//  oBusy         out  1                  1 while a commit is pending
//  oWrErr        out  1                  sticky: dropped write (busy or address >= NUM_TAP)
// BEHAVIOUR
//  Reset: all outputs 0; both banks 0; counter 0; state IDLE. All registers async-cleared by iRsn.
//  FSM: IDLE (iEnFilter=0), RUN, PEND (commit waiting for boundary).
//   IDLE->RUN when iEnFilter=1; RUN->PEND on iCommit; PEND->RUN after swap; RUN/PEND->IDLE when iEnFilter=0.
//  Strobe: counter 0..DIV-1, held at 0 in IDLE; oEnSample_300k registered, high exactly one cycle when
//   counter = DIV-1; first pulse in cycle DIV after the edge that enters RUN; period exactly DIV thereafter.
//  oEnMul=4'hF, oEnAdd=1, oEnAcc=1 in RUN and PEND; all 0 in IDLE (registered, same edge as state).
//  Shadow write: iCoeffWr with addr < NUM_TAP and state != PEND writes shadow[addr] next edge;
//   otherwise write dropped and oWrErr set next edge. iClrErr clears oWrErr; simultaneous error wins.
//  Commit in IDLE: active <= shadow on the next edge, oBusy never asserts.
//  Commit in RUN: oBusy=1 next cycle; swap on the edge ending the oEnSample_300k cycle (datapath samples
//   old bank on that edge, new bank from next strobe on); oBusy clears same edge.
//  Commit while PEND: ignored (no error). Commit with simultaneous write: write lands in shadow first,
//   then the commit proceeds (in IDLE the written value is included in the swap).
//  iEnFilter falling during PEND: pending swap performed on that edge, state IDLE, counter 0, oBusy 0.
//  iEnFilter re-rising: phase restarts from 0 (no phase memory).
//  Async reset mid-operation: immediate return to reset state; pending commit discarded.
//  No arithmetic on coefficients; values pass unchanged (signed COEFF_W).
// STRUCTURE
//  Shared package fir_ctrl_pkg: DIV default, NUM_TAP, COEFF_W, state encoding (IDLE=0,RUN=1,PEND=2).
//  Sub-module fir_strobe_gen: counter + registered strobe, inputs run/clear, output strobe and
//   last-cycle flag; top holds FSM, banks, error logic.
// TESTING
//  T1 reset: iRsn=0 mid-run -> all outputs 0 same cycle, oCoeff=0; release, iEnFilter=0 -> no strobe.
//  T2 strobe: iEnFilter=1 at cycle 0 -> pulses at cycles 40,80,120; width 1; oEnMul=4'hF from cycle 1.
//  T3 idle load: write taps 0..11 = 16'sh0100*(k+1), iCommit in IDLE -> oCoeff tap 5 = 16'h0600 next cycle.
//  T4 run commit: write tap 0 = -16'sd300, commit at cycle 10 after a strobe -> oBusy 1 for cycles 11..40,
//   tap 0 unchanged at strobe edge, equals 16'hFED4 from following cycle.
//  T5 errors: write addr 12 -> oWrErr=1, shadow unchanged; write during PEND dropped, oWrErr=1;
//   iClrErr -> 0.
//  T6 disable in PEND: commit then drop iEnFilter 5 cycles later -> swap that edge, oBusy=0, no strobe.

Source files
------------

// File: rtl/fir_ctrl_pkg.sv
// Shared definitions for the FIR coefficient scheduler: sizing defaults, FSM encoding
// and the sample-counter wrap helper.
package fir_ctrl_pkg;

  localparam int unsigned DIV_DEF     = 40;
  localparam int unsigned NUM_TAP_DEF = 12;
  localparam int unsigned COEFF_W_DEF = 16;
  localparam int unsigned NUM_SECT    = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2
  } fir_state_e;

  function automatic logic [7:0] cnt_wrap(input logic [7:0] cnt, input logic [7:0] last);
    return (cnt == last) ? '0 : cnt + 8'd1;
  endfunction

endpackage

// File: rtl/fir_strobe_gen.sv
// Sample-phase counter with a registered one-cycle strobe that is high while the
// counter sits at DIV-1.
module fir_strobe_gen
  import fir_ctrl_pkg::*;
#(
  parameter int unsigned DIV = DIV_DEF
) (
  input  logic iClk_12M,
  input  logic iRsn,
  input  logic run,
  input  logic clear,
  output logic strobe,
  output logic last
);

  localparam logic [7:0] LAST = 8'(DIV - 1);

  logic [7:0] cnt_q;
  logic [7:0] cnt_nxt;

  always_comb begin
    cnt_nxt = cnt_q;
    if (clear)
      cnt_nxt = '0;
    else if (run)
      cnt_nxt = cnt_wrap(cnt_q, LAST);
  end

  // Strobe is registered from the next count so it lines up with counter == DIV-1.
  always_ff @(posedge iClk_12M or negedge iRsn) begin
    if (!iRsn) begin
      cnt_q  <= '0;
      strobe <= 1'b0;
    end else begin
      cnt_q  <= cnt_nxt;
      strobe <= (cnt_nxt == LAST);
    end
  end

  assign last = (cnt_q == LAST);

endmodule

// File: rtl/fir_coeff_sched_ctrl.sv
// FIR datapath controller: sample strobe, datapath enables and a double-buffered
// coefficient bank swapped only on a sample boundary.
module fir_coeff_sched_ctrl
  import fir_ctrl_pkg::*;
#(
  parameter int unsigned DIV     = DIV_DEF,
  parameter int unsigned NUM_TAP = NUM_TAP_DEF,
  parameter int unsigned COEFF_W = COEFF_W_DEF
) (
  input  logic                       iClk_12M,
  input  logic                       iRsn,
  input  logic                       iEnFilter,
  input  logic                       iCoeffWr,
  input  logic [3:0]                 iCoeffAddr,
  input  logic [COEFF_W-1:0]         iCoeffData,
  input  logic                       iCommit,
  input  logic                       iClrErr,
  output logic                       oEnSample_300k,
  output logic [NUM_SECT-1:0]        oEnMul,
  output logic                       oEnAdd,
  output logic                       oEnAcc,
  output logic [NUM_TAP*COEFF_W-1:0] oCoeff,
  output logic                       oBusy,
  output logic                       oWrErr
);

  localparam int unsigned BANK_W = NUM_TAP * COEFF_W;

  fir_state_e        state_q;
  logic [BANK_W-1:0] shadow_q;
  logic [BANK_W-1:0] shadow_nxt;
  logic [BANK_W-1:0] active_q;
  logic              wr_ok;
  logic              wr_bad;
  logic              smp_last;
  logic              smp_strobe;

  assign wr_ok  = iCoeffWr && (32'(iCoeffAddr) < NUM_TAP) && (state_q != ST_PEND);
  assign wr_bad = iCoeffWr && !wr_ok;

  // Shadow including this cycle's write, so a same-cycle commit picks it up.
  always_comb begin
    shadow_nxt = shadow_q;
    for (int unsigned k = 0; k < NUM_TAP; k++) begin
      if (wr_ok && (32'(iCoeffAddr) == k))
        shadow_nxt[k*COEFF_W +: COEFF_W] = iCoeffData;
    end
  end

  always_ff @(posedge iClk_12M or negedge iRsn) begin
    if (!iRsn)
      shadow_q <= '0;
    else
      shadow_q <= shadow_nxt;
  end

  always_ff @(posedge iClk_12M or negedge iRsn) begin
    if (!iRsn)
      oWrErr <= 1'b0;
    else if (wr_bad)
      oWrErr <= 1'b1;
    else if (iClrErr)
      oWrErr <= 1'b0;
  end

  fir_strobe_gen #(
    .DIV(DIV)
  ) u_strobe (
    .iClk_12M (iClk_12M),
    .iRsn     (iRsn),
    .run      (state_q != ST_IDLE),
    .clear    (!iEnFilter),
    .strobe   (smp_strobe),
    .last     (smp_last)
  );

  // Next state is non-IDLE exactly when iEnFilter is high, so the enables follow it directly.
  always_ff @(posedge iClk_12M or negedge iRsn) begin
    if (!iRsn) begin
      state_q  <= ST_IDLE;
      active_q <= '0;
      oBusy    <= 1'b0;
      oEnMul   <= '0;
      oEnAdd   <= 1'b0;
      oEnAcc   <= 1'b0;
    end else begin
      oEnMul <= {NUM_SECT{iEnFilter}};
      oEnAdd <= iEnFilter;
      oEnAcc <= iEnFilter;
      case (state_q)
        ST_IDLE: begin
          if (iCommit)
            active_q <= shadow_nxt;
          if (iEnFilter)
            state_q <= ST_RUN;
        end
        ST_RUN: begin
          if (!iEnFilter) begin
            if (iCommit)
              active_q <= shadow_nxt;
            state_q <= ST_IDLE;
          end else if (iCommit) begin
            state_q <= ST_PEND;
            oBusy   <= 1'b1;
          end
        end
        ST_PEND: begin
          if (!iEnFilter || smp_last) begin
            active_q <= shadow_nxt;
            oBusy    <= 1'b0;
            state_q  <= iEnFilter ? ST_RUN : ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          oBusy   <= 1'b0;
        end
      endcase
    end
  end

  assign oEnSample_300k = smp_strobe;
  assign oCoeff         = active_q;

endmodule

// File: tb/tb_fir_coeff_sched_ctrl.sv
// Directed + randomized bench for fir_coeff_sched_ctrl against a rule-level reference model.
`timescale 1ns/1ps
module tb_fir_coeff_sched_ctrl;
  import fir_ctrl_pkg::*;

  localparam int DIV = 40;
  localparam int NT  = 12;
  localparam int CW  = 16;
  localparam int BW  = NT * CW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en, wr, commit, clr;
  logic [3:0]    addr;
  logic [CW-1:0] data;
  logic          o_smp, o_add, o_acc, o_busy, o_err;
  logic [3:0]    o_mul;
  logic [BW-1:0] o_coeff;

  always #42 clk = ~clk;

  fir_coeff_sched_ctrl #(
    .DIV(DIV),
    .NUM_TAP(NT),
    .COEFF_W(CW)
  ) dut (
    .iClk_12M       (clk),
    .iRsn           (rst_n),
    .iEnFilter      (en),
    .iCoeffWr       (wr),
    .iCoeffAddr     (addr),
    .iCoeffData     (data),
    .iCommit        (commit),
    .iClrErr        (clr),
    .oEnSample_300k (o_smp),
    .oEnMul         (o_mul),
    .oEnAdd         (o_add),
    .oEnAcc         (o_acc),
    .oCoeff         (o_coeff),
    .oBusy          (o_busy),
    .oWrErr         (o_err)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: enabled flag, cycles spent running, pending flag, both banks.
  bit            m_en, m_pend, m_err;
  int            m_age;
  logic [CW-1:0] m_sh  [NT];
  logic [CW-1:0] m_act [NT];

  task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [BW-1:0] pack_act();
    logic [BW-1:0] r;
    for (int k = 0; k < NT; k++) r[k*CW +: CW] = m_act[k];
    return r;
  endfunction

  function automatic bit exp_strobe();
    return m_en && (m_age % DIV == 0);
  endfunction

  task automatic model_reset();
    m_en = 0; m_pend = 0; m_err = 0; m_age = 0;
    for (int k = 0; k < NT; k++) begin
      m_sh[k]  = '0;
      m_act[k] = '0;
    end
  endtask

  task automatic model_edge();
    bit ok;
    bit boundary;
    boundary = exp_strobe();
    ok = wr && (int'(addr) < NT) && !m_pend;
    if (ok) m_sh[addr] = data;
    if (wr && !ok) m_err = 1;
    else if (clr)  m_err = 0;
    if (!m_en) begin
      if (commit) m_act = m_sh;
      m_en  = en;
      m_age = en ? 1 : 0;
      m_pend = 0;
    end else if (!en) begin
      if (m_pend || commit) m_act = m_sh;
      m_en = 0; m_age = 0; m_pend = 0;
    end else begin
      if (m_pend && boundary) begin
        m_act  = m_sh;
        m_pend = 0;
      end else if (!m_pend && commit) begin
        m_pend = 1;
      end
      m_age++;
    end
  endtask

  task automatic check_all();
    chk("strobe", BW'(o_smp),   BW'(exp_strobe()));
    chk("en_mul", BW'(o_mul),   BW'(m_en ? 4'hF : 4'h0));
    chk("en_add", BW'(o_add),   BW'(m_en));
    chk("en_acc", BW'(o_acc),   BW'(m_en));
    chk("busy",   BW'(o_busy),  BW'(m_pend));
    chk("wr_err", BW'(o_err),   BW'(m_err));
    chk("coeff",  o_coeff,      pack_act());
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic drive(input bit e, input bit w, input logic [3:0] a, input logic [CW-1:0] d,
                       input bit c, input bit cl);
    en = e; wr = w; addr = a; data = d; commit = c; clr = cl;
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int q[$];
    int nstr;
    bit got;
    rst_n = 1'b0;
    en = 0; wr = 0; addr = '0; data = '0; commit = 0; clr = 0;
    model_reset();
    #100;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    // strobe timing from enable
    for (int i = 1; i <= 125; i++) begin
      drive(1, 0, 4'd0, '0, 0, 0);
      if (i == 1) chk("t2_mul_cycle1", BW'(o_mul), BW'(4'hF));
      if (o_smp) q.push_back(i);
    end
    chk("t2_npulse", BW'(q.size()), BW'(3));
    if (q.size() == 3) begin
      chk("t2_pulse0", BW'(q[0]), BW'(40));
      chk("t2_pulse1", BW'(q[1]), BW'(80));
      chk("t2_pulse2", BW'(q[2]), BW'(120));
    end

    // idle bank load
    drive(0, 0, 4'd0, '0, 0, 0);
    for (int k = 0; k < NT; k++) drive(0, 1, 4'(k), 16'(32'h100 * (k + 1)), 0, 0);
    drive(0, 0, 4'd0, '0, 1, 0);
    chk("t3_tap5", BW'(o_coeff[5*CW +: CW]), BW'(16'h0600));
    chk("t3_busy", BW'(o_busy), BW'(1'b0));

    // commit while running, swap at sample boundary
    drive(1, 1, 4'd0, -16'sd300, 0, 0);
    got = 0;
    for (int i = 0; i < DIV + 2; i++) begin
      drive(1, 0, 4'd0, '0, 0, 0);
      if (o_smp) begin got = 1; break; end
    end
    chk("t4_strobe_seen", BW'(got), BW'(1'b1));
    for (int i = 1; i <= 9; i++) drive(1, 0, 4'd0, '0, 0, 0);
    drive(1, 0, 4'd0, '0, 1, 0);
    for (int i = 11; i <= DIV; i++) begin
      drive(1, 0, 4'd0, '0, 0, 0);
      if (i == 11) chk("t4_busy_start", BW'(o_busy), BW'(1'b1));
      if (i == DIV) begin
        chk("t4_strobe_at_swap", BW'(o_smp), BW'(1'b1));
        chk("t4_tap0_old", BW'(o_coeff[0 +: CW]), BW'(16'h0100));
      end
    end
    drive(1, 0, 4'd0, '0, 0, 0);
    chk("t4_tap0_new", BW'(o_coeff[0 +: CW]), BW'(16'hFED4));
    chk("t4_busy_end", BW'(o_busy), BW'(1'b0));

    // write errors
    drive(1, 1, 4'd12, 16'h7777, 0, 0);
    chk("t5_addr_err", BW'(o_err), BW'(1'b1));
    drive(1, 0, 4'd0, '0, 0, 1);
    chk("t5_clr", BW'(o_err), BW'(1'b0));
    drive(1, 0, 4'd0, '0, 1, 0);
    drive(1, 1, 4'd3, 16'h1234, 0, 0);
    chk("t5_pend_err", BW'(o_err), BW'(1'b1));
    drive(1, 0, 4'd0, '0, 0, 1);
    chk("t5_clr2", BW'(o_err), BW'(1'b0));
    got = 0;
    for (int i = 0; i < DIV + 2; i++) begin
      drive(1, 0, 4'd0, '0, 0, 0);
      if (!o_busy) begin got = 1; break; end
    end
    chk("t5_swap_done", BW'(got), BW'(1'b1));
    chk("t5_tap3_kept", BW'(o_coeff[3*CW +: CW]), BW'(16'h0400));

    // disable during pending commit
    drive(1, 1, 4'd1, 16'h5A5A, 1, 0);
    for (int i = 1; i <= 4; i++) drive(1, 0, 4'd0, '0, 0, 0);
    drive(0, 0, 4'd0, '0, 0, 0);
    chk("t6_busy", BW'(o_busy), BW'(1'b0));
    chk("t6_tap1", BW'(o_coeff[CW +: CW]), BW'(16'h5A5A));
    nstr = 0;
    for (int i = 0; i < 50; i++) begin
      drive(0, 0, 4'd0, '0, 0, 0);
      if (o_smp) nstr++;
    end
    chk("t6_no_strobe", BW'(nstr), BW'(0));

    // async reset mid-run with a pending commit
    for (int i = 0; i < 15; i++) drive(1, 0, 4'd0, '0, 0, 0);
    drive(1, 1, 4'd2, 16'hBEEF, 1, 0);
    #20;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("t1_coeff_zero", o_coeff, '0);
    en = 0; wr = 0; commit = 0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    nstr = 0;
    for (int i = 0; i < 45; i++) begin
      drive(0, 0, 4'd0, '0, 0, 0);
      if (o_smp) nstr++;
    end
    chk("t1_no_strobe", BW'(nstr), BW'(0));

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      bit e, w, c, cl;
      e  = ($urandom_range(0, 59) == 0) ? !en : en;
      w  = ($urandom_range(0, 3) == 0);
      c  = ($urandom_range(0, 14) == 0);
      cl = ($urandom_range(0, 9) == 0);
      if (!e && m_en) c = 0;
      drive(e, w, 4'($urandom_range(0, 13)), 16'($urandom), c, cl);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
